// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac -- multi-cycle SIMD custom-function unit for the CPU CFU slot.
//   Packed SIMD add, iterative packed dot-product into an internal accumulator,
//   and accumulator read / write / clear. The accumulator either saturates or
//   wraps at ACC_W bits, depending on SAT.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   en_i       command strobe (one-cycle pulse, honoured only when idle)
//   cfu_ctrl_i [2:0]=funct3 op, [9:3]=funct7 (bit0 = unsigned lanes, bit1 = high word on READ)
//   src1_i     operand 1
//   src2_i     operand 2
//   stall_o    high while a command executes
//   rslt_o     registered result, held until the next command completes

// Product of one lane, extended to the accumulator width.
module cfu_simd_mac_lane #(
  parameter int LANE_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              uns,
  output logic [ACC_W-1:0]  prod
);
  localparam int PW = 2*LANE_W + 2;

  // One extra bit per operand lets the same signed multiplier handle both
  // signed and unsigned lanes.
  logic signed [LANE_W:0]  ae, be;
  logic signed [PW-1:0]    full;
  logic [2*LANE_W-1:0]     pw;

  assign ae   = {uns ? 1'b0 : a[LANE_W-1], a};
  assign be   = {uns ? 1'b0 : b[LANE_W-1], b};
  assign full = PW'(ae) * PW'(be);
  assign pw   = full[2*LANE_W-1:0];
  assign prod = uns ? ACC_W'(pw) : ACC_W'($signed(pw));
endmodule

module cfu_simd_mac #(
  parameter int LANE_W = 8,
  parameter int MPC    = 1,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [9:0]  cfu_ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        stall_o,
  output logic [31:0] rslt_o
);
  localparam int LANES = 32 / LANE_W;
  localparam int N_MAC = LANES / MPC;
  localparam int CW    = (N_MAC > 1) ? $clog2(N_MAC) : 1;
  localparam int SH    = MPC * LANE_W;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                        state;
  logic [2:0]                    op_q;
  logic                          uns_q, hi_q;
  logic [31:0]                   s1_q, s2_q;
  logic [CW-1:0]                 cnt;
  logic [ACC_W-1:0]              acc, work, step;
  logic [MPC-1:0][ACC_W-1:0]     prod;
  logic [31:0]                   add_res;
  logic [ACC_W-1:0]              acc_sh;
  logic [31:0]                   hi_word;
  logic                          last_mac;

  // The latched operands are shifted down each DOT cycle, so the lanes due
  // this cycle always sit in the low MPC lane slots.
  for (genvar m = 0; m < MPC; m++) begin : g_mac
    cfu_simd_mac_lane #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane (
      .a    (s1_q[m*LANE_W +: LANE_W]),
      .b    (s2_q[m*LANE_W +: LANE_W]),
      .uns  (uns_q),
      .prod (prod[m])
    );
  end

  for (genvar l = 0; l < LANES; l++) begin : g_add
    assign add_res[l*LANE_W +: LANE_W] = s1_q[l*LANE_W +: LANE_W] + s2_q[l*LANE_W +: LANE_W];
  end

  // Signed add with optional clamp; applied after every single product so a
  // clamped partial sum can move back off the rail.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (SAT != 0 && (s[ACC_W] != s[ACC_W-1]))
      acc_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_add = s[ACC_W-1:0];
  endfunction

  always_comb begin
    step = work;
    for (int m = 0; m < MPC; m++) step = acc_add(step, prod[m]);
  end

  assign last_mac = (cnt == CW'(N_MAC - 1));

  // Upper accumulator bits sign-extended to a word; zero when there are none.
  assign acc_sh  = $signed(acc) >>> 32;
  assign hi_word = (ACC_W > 32) ? acc_sh[31:0] : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      stall_o <= 1'b0;
      rslt_o  <= '0;
      acc     <= '0;
      work    <= '0;
      cnt     <= '0;
      op_q    <= '0;
      uns_q   <= 1'b0;
      hi_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) begin
            op_q    <= cfu_ctrl_i[2:0];
            uns_q   <= cfu_ctrl_i[3];
            hi_q    <= cfu_ctrl_i[4];
            s1_q    <= src1_i;
            s2_q    <= src2_i;
            work    <= acc;
            cnt     <= '0;
            state   <= EXEC;
            stall_o <= 1'b1;
          end
        end
        EXEC: begin
          if (op_q != 3'd1 || last_mac) begin
            state   <= IDLE;
            stall_o <= 1'b0;
          end
          case (op_q)
            3'd0: rslt_o <= add_res;
            3'd1: begin
              if (last_mac) begin
                acc    <= step;
                rslt_o <= step[31:0];
              end else begin
                work <= step;
                cnt  <= cnt + 1'b1;
                s1_q <= s1_q >> SH;
                s2_q <= s2_q >> SH;
              end
            end
            3'd2: rslt_o <= hi_q ? hi_word : acc[31:0];
            3'd3: begin
              acc    <= ACC_W'($signed(s1_q));
              rslt_o <= acc[31:0];
            end
            3'd4: begin
              acc    <= '0;
              rslt_o <= acc[31:0];
            end
            default: rslt_o <= '0;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_simd_mac.sv
module tb_cfu_simd_mac;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [9:0]       ctrl = '0;
  logic [31:0]      s1 = '0, s2 = '0;
  logic [2:0]       stall;
  logic [2:0][31:0] rslt;
  int               sel = 0;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    logic [31:0] r;
    int          n;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // u0: defaults (wrapping), u1: saturating, u2: two MACs per cycle, 40-bit acc
  cfu_simd_mac #(.LANE_W(8), .MPC(1), .ACC_W(32), .SAT(0)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en && sel == 0), .cfu_ctrl_i(ctrl),
    .src1_i(s1), .src2_i(s2), .stall_o(stall[0]), .rslt_o(rslt[0]));
  cfu_simd_mac #(.LANE_W(8), .MPC(1), .ACC_W(32), .SAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en && sel == 1), .cfu_ctrl_i(ctrl),
    .src1_i(s1), .src2_i(s2), .stall_o(stall[1]), .rslt_o(rslt[1]));
  cfu_simd_mac #(.LANE_W(8), .MPC(2), .ACC_W(40), .SAT(0)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en && sel == 2), .cfu_ctrl_i(ctrl),
    .src1_i(s1), .src2_i(s2), .stall_o(stall[2]), .rslt_o(rslt[2]));

  // Monitor: a falling stall marks a completed command; compare result and
  // the number of stalled cycles against the scoreboard head.
  logic mon_prev = 1'b0;
  int   mon_cnt  = 0;
  always @(negedge clk) begin
    logic sm;
    exp_t e;
    sm = stall[sel];
    if (rst) begin
      mon_prev = 1'b0;
      mon_cnt  = 0;
    end else begin
      if (en && sm) begin
        checks++; errors++;
        $display("FAIL protocol: en_i asserted while stall_o high");
      end
      if (sm) mon_cnt++;
      else if (mon_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected: completion with rslt %h and empty scoreboard", rslt[sel]);
        end else begin
          e = sb.pop_front();
          if (rslt[sel] !== e.r || mon_cnt != e.n) begin
            errors++;
            $display("FAIL %s: got %h stall %0d, expected %h stall %0d", e.name, rslt[sel], mon_cnt, e.r, e.n);
          end
        end
        pops++;
        mon_cnt = 0;
      end
      mon_prev = sm;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(input string name, input logic [9:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int n);
    int start;
    sb.push_back('{e, n, name});
    start = pops;
    @(posedge clk); #1;
    ctrl = c; s1 = a; s2 = b; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    // Scramble operands during EXEC; they must have been latched.
    ctrl = 10'($urandom); s1 = $urandom; s2 = $urandom;
    for (int i = 0; i < 100 && pops == start; i++) @(posedge clk);
    if (pops == start) begin
      checks++; errors++;
      $display("FAIL timeout: %s never completed", name);
      sb.delete();
    end
  endtask

  localparam logic [9:0] ADD = 10'h000, DOT = 10'h001, DOTU = 10'h009, RD = 10'h002,
                         RDHI = 10'h012, WR = 10'h003, CLR = 10'h004;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_stall", 32'(stall[k]), 32'd0);
      check("reset_rslt", rslt[k], 32'd0);
    end

    sel = 0;
    cmd("read_after_reset", RD,   32'h0,        32'h0,        32'h00000000, 1);
    cmd("simd_add",         ADD,  32'h01FF7F80, 32'h01010101, 32'h02008081, 1);
    cmd("clear0",           CLR,  32'h0,        32'h0,        32'h00000000, 1);
    cmd("dot_basic",        DOT,  32'h01020304, 32'h05060708, 32'h00000046, 4);
    cmd("dot_accum",        DOT,  32'h01020304, 32'h05060708, 32'h0000008C, 4);
    cmd("read_hi_acc32",    RDHI, 32'h0,        32'h0,        32'h00000000, 1);
    cmd("clear_prev",       CLR,  32'h0,        32'h0,        32'h0000008C, 1);
    cmd("dot_signed",       DOT,  32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFC, 4);
    cmd("clear_neg",        CLR,  32'h0,        32'h0,        32'hFFFFFFFC, 1);
    cmd("dot_unsigned",     DOTU, 32'hFFFFFFFF, 32'h01010101, 32'h000003FC, 4);
    cmd("write_prev",       WR,   32'h7FFFFFF0, 32'h0,        32'h000003FC, 1);
    cmd("dot_wrap",         DOT,  32'h7F7F7F7F, 32'h7F7F7F7F, 32'h8000FBF4, 4);
    cmd("reserved7",        10'h3FF, 32'hDEADBEEF, 32'h1,     32'h00000000, 1);
    cmd("read_after_rsvd",  RD,   32'h0,        32'h0,        32'h8000FBF4, 1);

    sel = 1;
    cmd("sat_write",        WR,   32'h7FFFFFF0, 32'h0,        32'h00000000, 1);
    cmd("sat_pos",          DOT,  32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFFF, 4);
    cmd("sat_write2",       WR,   32'h80000010, 32'h0,        32'h7FFFFFFF, 1);
    cmd("sat_neg",          DOT,  32'h7F7F7F7F, 32'h81818181, 32'h80000000, 4);
    cmd("sat_write3",       WR,   32'h7FFFFFF0, 32'h0,        32'h80000000, 1);
    cmd("sat_per_step",     DOT,  32'h7F7F7F7F, 32'h81817F7F, 32'h7FFF81FD, 4);

    sel = 2;
    cmd("mpc2_clear",       CLR,  32'h0,        32'h0,        32'h00000000, 1);
    cmd("mpc2_dot",         DOT,  32'h01020304, 32'h05060708, 32'h00000046, 2);
    cmd("acc40_write",      WR,   32'h80000000, 32'h0,        32'h00000046, 1);
    cmd("acc40_read_hi",    RDHI, 32'h0,        32'h0,        32'hFFFFFFFF, 1);
    cmd("acc40_read_lo",    RD,   32'h0,        32'h0,        32'h80000000, 1);
    cmd("acc40_dotu",       DOTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h8003F804, 2);
    cmd("acc40_read_hi2",   RDHI, 32'h0,        32'h0,        32'hFFFFFFFF, 1);

    // Reset in the second EXEC cycle of a DOT discards it and clears acc.
    sel = 0;
    cmd("pre_abort_write",  WR,   32'h00000055, 32'h0,        32'h8000FBF4, 1);
    @(posedge clk); #1;
    ctrl = DOT; s1 = 32'h01020304; s2 = 32'h05060708; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_stall", 32'(stall[0]), 32'd0);
    cmd("read_after_abort", RD,   32'h0,        32'h0,        32'h00000000, 1);
    cmd("write_1234",       WR,   32'h00001234, 32'h0,        32'h00000000, 1);
    cmd("reserved5",        10'h005, 32'h1,     32'h2,        32'h00000000, 1);
    cmd("read_keep",        RD,   32'h0,        32'h0,        32'h00001234, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
